// File: rtl/mdc_acondicionador_entradas.sv
// Input conditioner for maquina_de_cafe: synchronise, debounce and latch coin/selection inputs.
// Optional MDC_TIMEOUT_EN adds an idle counter that auto-refunds a coin left unused.
module mdc_acondicionador_entradas #(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin10_raw,
    input  logic       coin5_raw,
    input  logic       btn_cafe_raw,
    input  logic       btn_te_raw,
    input  logic       agua_raw,
    input  logic       cafe_raw,
    input  logic [2:0] fsm_out,
    output logic       hm,
    output logic       md,
    output logic       mc,
    output logic       bp,
    output logic       bc,
    output logic       bt,
    output logic       ha,
    output logic       hc,
    output logic       coin_reject,
    output logic       timeout_refund
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    // bit order: coin10, coin5, btn_cafe, btn_te, agua, cafe
    logic [5:0]    raw;
    logic [5:0]    s1, s2, deb, deb_d, rise;
    logic [CW-1:0] cnt [6];

    assign raw  = {cafe_raw, agua_raw, btn_te_raw, btn_cafe_raw, coin5_raw, coin10_raw};
    assign rise = deb & ~deb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 6; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic c10_r, c5_r, cafe_r, te_r, clr, fire;
    assign c10_r  = rise[0];
    assign c5_r   = rise[1];
    assign cafe_r = rise[2];
    assign te_r   = rise[3];
    assign clr    = (fsm_out != 3'b000);

`ifdef MDC_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       idle_run;
    assign idle_run = hm && !bp && !clr;
    assign fire     = idle_run && (idle_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 idle_cnt <= '0;
        else if (!idle_run || fire) idle_cnt <= '0;
        else                     idle_cnt <= idle_cnt + 8'd1;
    end
`else
    // timeout feature compiled out; constant-false
    assign fire = (TIMEOUT_CYCLES < 0);
`endif

    logic hm_n, md_n, mc_n, bp_n, bc_n, bt_n, rej_n, to_n;

    always_comb begin
        hm_n  = hm;
        md_n  = md;
        mc_n  = mc;
        bp_n  = bp;
        bc_n  = bc;
        bt_n  = bt;
        rej_n = 1'b0;
        to_n  = 1'b0;
        if (clr) begin
            // clear first, then a coin arriving this cycle is still taken
            hm_n = 1'b0;
            md_n = 1'b0;
            mc_n = 1'b0;
            bp_n = 1'b0;
            bc_n = 1'b0;
            bt_n = 1'b0;
            if (c10_r || c5_r) begin
                hm_n = 1'b1;
                md_n = c10_r;
                mc_n = ~c10_r;
            end
            rej_n = c10_r & c5_r;
        end else begin
            if (fire) begin
                hm_n = 1'b0;
                md_n = 1'b0;
                mc_n = 1'b0;
                to_n = 1'b1;
            end
            if (c10_r || c5_r) begin
                if (hm) begin
                    rej_n = 1'b1;
                end else begin
                    hm_n  = 1'b1;
                    md_n  = c10_r;
                    mc_n  = ~c10_r;
                    rej_n = c10_r & c5_r;
                end
            end
            if (hm && !bp && !fire && (cafe_r || te_r)) begin
                bp_n = 1'b1;
                bc_n = cafe_r;
                bt_n = ~cafe_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hm             <= 1'b0;
            md             <= 1'b0;
            mc             <= 1'b0;
            bp             <= 1'b0;
            bc             <= 1'b0;
            bt             <= 1'b0;
            coin_reject    <= 1'b0;
            timeout_refund <= 1'b0;
        end else begin
            hm             <= hm_n;
            md             <= md_n;
            mc             <= mc_n;
            bp             <= bp_n;
            bc             <= bc_n;
            bt             <= bt_n;
            coin_reject    <= rej_n;
            timeout_refund <= to_n;
        end
    end

    assign ha = deb[4];
    assign hc = deb[5];

endmodule

// File: tb/tb_mdc_acondicionador_entradas.sv
// Scoreboard bench for mdc_acondicionador_entradas: stimulus pushes expected output
// vectors with their arrival cycle, a negedge monitor pops one on every output change.
module tb_mdc_acondicionador_entradas;

    localparam int HM = 9, MD = 8, MC = 7, BP = 6, BC = 5, BT = 4, HA = 3, HC = 2, CR = 1, TR = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin10_raw, coin5_raw, btn_cafe_raw, btn_te_raw, agua_raw, cafe_raw;
    logic [2:0] fsm_out;
    logic       hm, md, mc, bp, bc, bt, ha, hc, coin_reject, timeout_refund;

    mdc_acondicionador_entradas dut (
        .clk           (clk),
        .rst           (rst),
        .coin10_raw    (coin10_raw),
        .coin5_raw     (coin5_raw),
        .btn_cafe_raw  (btn_cafe_raw),
        .btn_te_raw    (btn_te_raw),
        .agua_raw      (agua_raw),
        .cafe_raw      (cafe_raw),
        .fsm_out       (fsm_out),
        .hm            (hm),
        .md            (md),
        .mc            (mc),
        .bp            (bp),
        .bc            (bc),
        .bt            (bt),
        .ha            (ha),
        .hc            (hc),
        .coin_reject   (coin_reject),
        .timeout_refund(timeout_refund)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] vec;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    logic [9:0] prev, cur, m;
    int         c;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] outs();
        return {hm, md, mc, bp, bc, bt, ha, hc, coin_reject, timeout_refund};
    endfunction

    task automatic push(input string name, input int at);
        exp_t e;
        e.name = name;
        e.vec  = m;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur = outs();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, want no change from %b", cur, cyc, prev);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (cur !== e.vec || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s: got %b at cycle %0d, want %b at cycle %0d", e.name, cur, cyc, e.vec, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {coin10_raw, coin5_raw, btn_cafe_raw, btn_te_raw, agua_raw, cafe_raw} = '0;
        fsm_out = 3'b000;
        m = '0;
        tick(2);
        checks++;
        if (outs() !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got %b, want %b", outs(), 10'b0);
        end
        prev   = 10'b0;
        mon_en = 1'b1;
        rst    = 1'b0;
        tick(2);

        // coin10 then coffee, water level alongside
        c = cyc; coin10_raw = 1'b1;
        m[HM] = 1; m[MD] = 1; push("coin10_latch", c + 7);
        tick(5); coin10_raw = 1'b0; tick(4);
        c = cyc; btn_cafe_raw = 1'b1; agua_raw = 1'b1;
        m[HA] = 1; push("agua_level", c + 6);
        m[BP] = 1; m[BC] = 1; push("cafe_sel", c + 7);
        tick(5); btn_cafe_raw = 1'b0; tick(5);

        // extra coin while held
        c = cyc; coin10_raw = 1'b1;
        m[CR] = 1; push("reject_pulse", c + 7);
        m[CR] = 0; push("reject_end", c + 8);
        tick(5); coin10_raw = 1'b0; tick(6);

        // button with bp already set: ignored
        btn_te_raw = 1'b1; tick(5); btn_te_raw = 1'b0; tick(6);

        // clear coinciding with a coin5 edge
        c = cyc; coin5_raw = 1'b1;
        tick(6); fsm_out = 3'b100;
        m[HM] = 1; m[MD] = 0; m[MC] = 1; m[BP] = 0; m[BC] = 0; m[BT] = 0;
        push("clear_coin5", c + 7);
        tick(1); fsm_out = 3'b000; coin5_raw = 1'b0; tick(6);

        c = cyc; fsm_out = 3'b001;
        m[HM] = 0; m[MC] = 0; push("clear", c + 1);
        tick(1); fsm_out = 3'b000; tick(2);

        // button with no coin: ignored
        btn_cafe_raw = 1'b1; tick(5); btn_cafe_raw = 1'b0; tick(6);

        // 3-sample glitch must not pass the debouncer
        coin5_raw = 1'b1; tick(3); coin5_raw = 1'b0; tick(8);
        checks++;
        if (hm !== 1'b0) begin
            errors++;
            $display("FAIL glitch_hm: got %b, want 0", hm);
        end

        c = cyc; coin5_raw = 1'b1;
        m[HM] = 1; m[MC] = 1; push("coin5_pulse", c + 7);
        tick(4); coin5_raw = 1'b0; tick(8);

        c = cyc; btn_te_raw = 1'b1;
        m[BP] = 1; m[BT] = 1; push("tea_sel", c + 7);
        tick(5); btn_te_raw = 1'b0; tick(6);

        c = cyc; fsm_out = 3'b010;
        m[HM] = 0; m[MC] = 0; m[BP] = 0; m[BT] = 0; push("clear2", c + 1);
        tick(1); fsm_out = 3'b000; tick(1);

        // simultaneous coins: 10 wins plus reject
        c = cyc; coin10_raw = 1'b1; coin5_raw = 1'b1;
        m[HM] = 1; m[MD] = 1; m[CR] = 1; push("dual_coin", c + 7);
        m[CR] = 0; push("dual_coin_end", c + 8);
        tick(5); coin10_raw = 1'b0; coin5_raw = 1'b0; tick(4);

        // simultaneous buttons: coffee wins
        c = cyc; btn_cafe_raw = 1'b1; btn_te_raw = 1'b1;
        m[BP] = 1; m[BC] = 1; push("dual_btn", c + 7);
        tick(5); btn_cafe_raw = 1'b0; btn_te_raw = 1'b0; tick(6);

        c = cyc; cafe_raw = 1'b1;
        m[HC] = 1; push("cafe_level", c + 6);
        tick(8);
        c = cyc; cafe_raw = 1'b0; agua_raw = 1'b0;
        m[HC] = 0; m[HA] = 0; push("levels_low", c + 6);
        tick(8);

        // clear held for several cycles
        c = cyc; fsm_out = 3'b111;
        m[HM] = 0; m[MD] = 0; m[BP] = 0; m[BC] = 0; push("clear3", c + 1);
        tick(3); fsm_out = 3'b000; tick(2);

        // button edge landing in a clear cycle is dropped
        c = cyc; coin10_raw = 1'b1;
        m[HM] = 1; m[MD] = 1; push("coin10_again", c + 7);
        tick(5); coin10_raw = 1'b0; tick(4);
        c = cyc; btn_cafe_raw = 1'b1;
        tick(6); fsm_out = 3'b001;
        m[HM] = 0; m[MD] = 0; push("clear_drops_btn", c + 7);
        tick(1); fsm_out = 3'b000; tick(4); btn_cafe_raw = 1'b0; tick(7);

        // coin left unused
        c = cyc; coin5_raw = 1'b1;
        m[HM] = 1; m[MC] = 1; push("coin_hold", c + 7);
        tick(5); coin5_raw = 1'b0;
`ifdef MDC_TIMEOUT_EN
        m[HM] = 0; m[MC] = 0; m[TR] = 1; push("timeout_refund", c + 23);
        m[TR] = 0; push("timeout_refund_end", c + 24);
        tick(30);
`else
        tick(100);
        checks++;
        if (hm !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_timeout: got hm=%b, want 1", hm);
        end
        c = cyc; fsm_out = 3'b001;
        m[HM] = 0; m[MC] = 0; push("clear4", c + 1);
        tick(1); fsm_out = 3'b000; tick(2);
`endif

        // asynchronous reset mid-activity
        c = cyc; coin10_raw = 1'b1;
        m[HM] = 1; m[MD] = 1; push("coin10_pre_reset", c + 7);
        tick(5); coin10_raw = 1'b0; tick(4);
        c = cyc; btn_cafe_raw = 1'b1;
        m[BP] = 1; m[BC] = 1; push("cafe_pre_reset", c + 7);
        tick(5); btn_cafe_raw = 1'b0; tick(4);
        agua_raw = 1'b1; tick(2);
        @(posedge clk); #2;
        rst = 1'b1;
        {coin10_raw, coin5_raw, btn_cafe_raw, btn_te_raw, agua_raw, cafe_raw} = '0;
        m = '0; push("async_reset", cyc);
        #1;
        checks++;
        if (outs() !== 10'b0) begin
            errors++;
            $display("FAIL async_reset_direct: got %b, want %b", outs(), 10'b0);
        end
        tick(2); rst = 1'b0; tick(10);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no change, want %b at cycle %0d", e.name, e.vec, e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
